// File: rtl/conv_seq_ctrl.sv
// conv_seq_ctrl: sequencer for the sliding-window convolution datapath.
// Steps the address generator through one kernel window at a time. For each
// window it fetches m*m taps, lets the read latency drain, writes one result,
// and slides. It stops once the address generator raises conv_complete.
//
// Ports
//   clk, rstn      : clock, synchronous active-low reset
//   start, m       : frame request and kernel size (sampled in IDLE only)
//   conv_complete  : address generator reports the final slide
//   fetch, slide   : address-generator controls
//   pixel_count    : kernel tap index during FETCH, 0 otherwise
//   pix_valid      : memory data valid for the MAC (fetch delayed RD_LAT)
//   acc_clr        : clear the MAC accumulator, aligned with tap 0 data
//   res_we         : one result-RAM write per window
//   win_count      : windows written since the last accepted start (saturating)
//   busy, done     : frame in progress / frame finished
//   err            : sticky illegal-m flag from the last start attempt
module conv_seq_ctrl #(
  parameter int unsigned RD_LAT = 1,
  parameter int unsigned CW     = 10
) (
  input  logic          clk,
  input  logic          rstn,
  input  logic          start,
  input  logic [3:0]    m,
  input  logic          conv_complete,
  output logic          fetch,
  output logic          slide,
  output logic [CW-1:0] pixel_count,
  output logic          pix_valid,
  output logic          acc_clr,
  output logic          res_we,
  output logic [15:0]   win_count,
  output logic          busy,
  output logic          done,
  output logic          err
);

  localparam int unsigned KW = 8;
  localparam int unsigned DW = 3;
  localparam int unsigned WW = 16;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_DRAIN,
    S_WRITE,
    S_SLIDE,
    S_DONE
  } state_t;

  state_t            state, state_d;
  logic [KW-1:0]     kk, kk_d;
  logic [DW-1:0]     drain_cnt, drain_cnt_d;
  logic [CW-1:0]     pcnt_d;
  logic [WW-1:0]     win_d;
  logic              err_d;
  logic [RD_LAT-1:0] v_pipe;
  logic [RD_LAT-1:0] z_pipe;

  // Next-state and datapath-register update.
  always_comb begin
    state_d     = state;
    kk_d        = kk;
    drain_cnt_d = drain_cnt;
    pcnt_d      = pixel_count;
    win_d       = win_count;
    err_d       = err;
    unique case (state)
      S_IDLE: begin
        if (start) begin
          // For a 4-bit m, odd is exactly the legal set 1..15.
          if (m[0]) begin
            kk_d    = KW'({4'd0, m} * {4'd0, m});
            win_d   = '0;
            err_d   = 1'b0;
            pcnt_d  = '0;
            state_d = S_FETCH;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      S_FETCH: begin
        if (pixel_count == CW'(kk - KW'(1))) begin
          pcnt_d      = '0;
          drain_cnt_d = DW'(RD_LAT - 1);
          state_d     = S_DRAIN;
        end else begin
          pcnt_d = pixel_count + CW'(1);
        end
      end
      S_DRAIN: begin
        if (drain_cnt == '0) begin
          state_d = S_WRITE;
        end else begin
          drain_cnt_d = drain_cnt - DW'(1);
        end
      end
      S_WRITE: begin
        if (win_count != '1) begin
          win_d = win_count + WW'(1);
        end
        state_d = S_SLIDE;
      end
      // conv_complete settles on the generator's falling edge inside SLIDE.
      S_SLIDE: state_d = conv_complete ? S_DONE : S_FETCH;
      S_DONE:  state_d = S_DONE;
      default: state_d = S_IDLE;
    endcase
  end

  // State, counters, registered control outputs and the data-valid pipeline.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      state       <= S_IDLE;
      kk          <= '0;
      drain_cnt   <= '0;
      pixel_count <= '0;
      win_count   <= '0;
      err         <= 1'b0;
      fetch       <= 1'b0;
      slide       <= 1'b0;
      res_we      <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
      v_pipe      <= '0;
      z_pipe      <= '0;
    end else begin
      state       <= state_d;
      kk          <= kk_d;
      drain_cnt   <= drain_cnt_d;
      pixel_count <= pcnt_d;
      win_count   <= win_d;
      err         <= err_d;
      fetch       <= (state_d == S_FETCH);
      slide       <= (state_d == S_SLIDE);
      res_we      <= (state_d == S_WRITE);
      busy        <= (state_d inside {S_FETCH, S_DRAIN, S_WRITE, S_SLIDE});
      done        <= (state_d == S_DONE);
      // Shift in at bit 0; the cast drops the oldest entry.
      v_pipe      <= RD_LAT'({v_pipe, fetch});
      z_pipe      <= RD_LAT'({z_pipe, fetch && (pixel_count == '0)});
    end
  end

  assign pix_valid = v_pipe[RD_LAT-1];
  assign acc_clr   = z_pipe[RD_LAT-1];

endmodule

// File: tb/tb_conv_seq_ctrl.sv
// Directed bench for conv_seq_ctrl: one instance at RD_LAT=1, one at RD_LAT=3.
module tb_conv_seq_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rstn;
  logic        start1, cc1, start3, cc3;
  logic [3:0]  m1, m3;
  logic        fetch1, slide1, pv1, ac1, we1, busy1, done1, err1;
  logic        fetch3, slide3, pv3, ac3, we3, busy3, done3, err3;
  logic [9:0]  pc1, pc3;
  logic [15:0] wc1, wc3;

  int checks   = 0;
  int failures = 0;

  conv_seq_ctrl #(.RD_LAT(1), .CW(10)) u_dut1 (
    .clk(clk), .rstn(rstn), .start(start1), .m(m1), .conv_complete(cc1),
    .fetch(fetch1), .slide(slide1), .pixel_count(pc1), .pix_valid(pv1),
    .acc_clr(ac1), .res_we(we1), .win_count(wc1), .busy(busy1),
    .done(done1), .err(err1)
  );

  conv_seq_ctrl #(.RD_LAT(3), .CW(10)) u_dut3 (
    .clk(clk), .rstn(rstn), .start(start3), .m(m3), .conv_complete(cc3),
    .fetch(fetch3), .slide(slide3), .pixel_count(pc3), .pix_valid(pv3),
    .acc_clr(ac3), .res_we(we3), .win_count(wc3), .busy(busy3),
    .done(done3), .err(err3)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Advance one cycle; outputs are sampled 1 time unit after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rstn = 1'b0;
    step();
    step();
    rstn = 1'b1;
  endtask

  // fetch, slide and res_we must never overlap.
  always @(negedge clk) begin
    chk("excl1", 32'($countones({fetch1, slide1, we1}) <= 1), 32'd1);
    chk("excl3", 32'($countones({fetch3, slide3, we3}) <= 1), 32'd1);
  end

  initial begin
    #500000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n_we, n_slide, last_we, c, r;
    rstn   = 1'b0;
    start1 = 1'b0; cc1 = 1'b0; m1 = 4'd0;
    start3 = 1'b0; cc3 = 1'b0; m3 = 4'd0;

    // Reset values.
    do_reset();
    step();
    chk("rst_ctl1", 32'({fetch1, slide1, pv1, ac1, we1, busy1, done1, err1}), 32'd0);
    chk("rst_pc1", 32'(pc1), 32'd0);
    chk("rst_wc1", 32'(wc1), 32'd0);
    chk("rst_ctl3", 32'({fetch3, slide3, pv3, ac3, we3, busy3, done3, err3}), 32'd0);

    // Illegal m: m=4 on dut1, m=0 on dut3.
    start1 = 1'b1; m1 = 4'd4;
    start3 = 1'b1; m3 = 4'd0;
    step();
    start1 = 1'b0; start3 = 1'b0;
    chk("bad_err1", 32'(err1), 32'd1);
    chk("bad_busy1", 32'(busy1), 32'd0);
    chk("bad_fetch1", 32'(fetch1), 32'd0);
    chk("bad_err3", 32'(err3), 32'd1);
    step();
    chk("bad_err1_sticky", 32'(err1), 32'd1);
    chk("bad_fetch1_later", 32'(fetch1), 32'd0);

    // Single window, m=3, RD_LAT=1, conv_complete held high; start in cycle 0.
    m1 = 4'd3; cc1 = 1'b1; start1 = 1'b1;
    for (int cy = 1; cy <= 15; cy++) begin
      step();
      if (cy == 1) start1 = 1'b0;
      if (cy == 15) start1 = 1'b0;
      chk($sformatf("sw_fetch@%0d", cy), 32'(fetch1), 32'(cy >= 1 && cy <= 9));
      chk($sformatf("sw_pc@%0d", cy), 32'(pc1), (cy <= 9) ? 32'(cy - 1) : 32'd0);
      chk($sformatf("sw_pv@%0d", cy), 32'(pv1), 32'(cy >= 2 && cy <= 10));
      chk($sformatf("sw_ac@%0d", cy), 32'(ac1), 32'(cy == 2));
      chk($sformatf("sw_we@%0d", cy), 32'(we1), 32'(cy == 11));
      chk($sformatf("sw_slide@%0d", cy), 32'(slide1), 32'(cy == 12));
      chk($sformatf("sw_busy@%0d", cy), 32'(busy1), 32'(cy <= 12));
      chk($sformatf("sw_done@%0d", cy), 32'(done1), 32'(cy >= 13));
      chk($sformatf("sw_wc@%0d", cy), 32'(wc1), (cy >= 12) ? 32'd1 : 32'd0);
      chk($sformatf("sw_err@%0d", cy), 32'(err1), 32'd0);
      // start pulsed in DONE must be ignored.
      if (cy == 14) start1 = 1'b1;
    end

    // Multi-window frame: conv_complete raised during the 5th slide.
    do_reset();
    cc1 = 1'b0; m1 = 4'd3; start1 = 1'b1;
    n_we = 0; n_slide = 0; last_we = -1; c = 0;
    while (!done1 && c < 200) begin
      step();
      c++;
      if (c == 1) start1 = 1'b0;
      if (c == 10) begin
        chk("mw_in_drain", 32'({fetch1, busy1, we1}), 32'b010);
        start1 = 1'b1; m1 = 4'd5;
      end
      if (c == 11) begin
        start1 = 1'b0; m1 = 4'd3;
      end
      if (we1) begin
        n_we++;
        if (last_we >= 0) chk($sformatf("mw_gap%0d", n_we), 32'(c - last_we), 32'd12);
        last_we = c;
      end
      if (slide1) begin
        n_slide++;
        chk($sformatf("mw_wc_slide%0d", n_slide), 32'(wc1), 32'(n_slide));
        if (n_slide == 5) cc1 = 1'b1;
      end
    end
    chk("mw_done", 32'(done1), 32'd1);
    chk("mw_done_cycle", 32'(c), 32'd61);
    chk("mw_n_we", 32'(n_we), 32'd5);
    chk("mw_n_slide", 32'(n_slide), 32'd5);
    chk("mw_wc", 32'(wc1), 32'd5);

    // m=1, RD_LAT=3: two 6-cycle windows.
    do_reset();
    m3 = 4'd1; cc3 = 1'b0; start3 = 1'b1;
    for (int cy = 1; cy <= 14; cy++) begin
      step();
      if (cy == 1) start3 = 1'b0;
      if (cy <= 12) begin
        r = (cy - 1) % 6;
        chk($sformatf("m1_fetch@%0d", cy), 32'(fetch3), 32'(r == 0));
        chk($sformatf("m1_pv@%0d", cy), 32'(pv3), 32'(r == 3));
        chk($sformatf("m1_ac@%0d", cy), 32'(ac3), 32'(r == 3));
        chk($sformatf("m1_we@%0d", cy), 32'(we3), 32'(r == 4));
        chk($sformatf("m1_slide@%0d", cy), 32'(slide3), 32'(r == 5));
        chk($sformatf("m1_pc@%0d", cy), 32'(pc3), 32'd0);
        chk($sformatf("m1_busy@%0d", cy), 32'(busy3), 32'd1);
        if (cy == 12) cc3 = 1'b1;
      end else begin
        chk($sformatf("m1_done@%0d", cy), 32'(done3), 32'd1);
        chk($sformatf("m1_busy@%0d", cy), 32'(busy3), 32'd0);
      end
    end
    chk("m1_wc", 32'(wc3), 32'd2);

    // Reset in the middle of FETCH with m=5.
    do_reset();
    cc1 = 1'b0; m1 = 4'd5; start1 = 1'b1;
    step();
    start1 = 1'b0;
    for (int i = 0; i < 12; i++) step();
    chk("rf_pc_before", 32'(pc1), 32'd12);
    chk("rf_fetch_before", 32'(fetch1), 32'd1);
    rstn = 1'b0;
    step();
    rstn = 1'b1;
    chk("rf_ctl_after", 32'({fetch1, slide1, pv1, ac1, we1, busy1, done1, err1}), 32'd0);
    chk("rf_pc_after", 32'(pc1), 32'd0);
    chk("rf_wc_after", 32'(wc1), 32'd0);
    for (int i = 0; i < 20; i++) begin
      step();
      chk($sformatf("rf_idle_we@%0d", i), 32'({we1, fetch1, busy1}), 32'd0);
    end
    start1 = 1'b1;
    step();
    start1 = 1'b0;
    chk("rf_restart_fetch", 32'(fetch1), 32'd1);
    chk("rf_restart_pc0", 32'(pc1), 32'd0);
    step();
    chk("rf_restart_pc1", 32'(pc1), 32'd1);
    chk("rf_restart_pv", 32'({pv1, ac1}), 32'b11);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
